// File: rtl/addf_sub_pkg.sv
// Shared constants and the stage payload type for the pipelined ADDF subtractor.
// Optional signed-overflow output is enabled with the SUB_OVF_EN macro.
package addf_sub_pkg;

  localparam int unsigned DEF_WIDTH  = 15;
  localparam int unsigned DEF_STAGES = 3;
  localparam int unsigned DEF_SEG    = DEF_WIDTH / DEF_STAGES;

  function automatic bit width_ok(int unsigned width, int unsigned stages);
    return (stages != 0) && ((width % stages) == 0);
  endfunction

  // a_hi/b_hi carry the not-yet-consumed operand bits; d_lo the finished result bits.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] a_hi;
    logic [DEF_WIDTH-1:0] b_hi;
    logic [DEF_WIDTH-1:0] d_lo;
  } stage_t;

endpackage

// File: rtl/addf_sub_pipe_if.sv
// Operand/result handshake bundle for addf_sub_pipe.
// slave is the subtractor side, master the producer/consumer side.
interface addf_sub_pipe_if #(
  parameter int unsigned WIDTH = addf_sub_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, bi, out_ready,
    output in_ready, out_valid, d, bo, ovf
  );

  modport master (
    output in_valid, a, b, bi, out_ready,
    input  in_ready, out_valid, d, bo, ovf
  );
endinterface

// File: rtl/addf_sub_slice.sv
// Combinational SEG-bit CC_ADDF chain computing a + ~b + ci, i.e. one subtract segment.
module addf_sub_slice #(
  parameter int unsigned SEG = addf_sub_pkg::DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  logic [SEG:0]   c;
  logic [SEG-1:0] nb;

  // One CC_ADDF per bit: S = A ^ B ^ CI, CO = A&B | CI&(A^B), with B = ~b.
  always_comb begin
    nb   = ~b;
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = a[i] ^ nb[i] ^ c[i];
      c[i+1] = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
    end
    co = c[SEG];
  end
endmodule

// File: rtl/addf_sub_pipe.sv
// Pipelined subtractor d = a - b - bi with borrow-out, carry chain split over STAGES registers.
// Define SUB_OVF_EN to get a registered two's-complement overflow flag on ovf.
module addf_sub_pipe
  import addf_sub_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input logic            clk,
  input logic            rst_n,
  addf_sub_pipe_if.slave bus
);
  localparam int unsigned SEG = WIDTH / STAGES;
  // Idle carry is 1 (no borrow) so bo reads 0 out of reset.
  localparam stage_t STAGE_RST = '{valid: 1'b0, carry: 1'b1, default: '0};

  if (!width_ok(WIDTH, STAGES)) begin : g_chk_split
    $error("addf_sub_pipe: WIDTH must be a multiple of STAGES");
  end
  if (WIDTH != DEF_WIDTH) begin : g_chk_width
    $error("addf_sub_pipe: WIDTH must match the stage_t payload width");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;

  // A stage moves when any stage from it to the output has a hole, or the sink takes a beat.
  always_comb begin
    logic full;
    adv  = '0;
    full = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        full = full & vld[j];
      end
      adv[k] = !full || bus.out_ready;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_a, src_b, src_d;
    logic             src_ci, src_v;
    logic [SEG-1:0]   sum;
    logic             co;
    stage_t           nxt, q;

    if (k == 0) begin : g_head
      assign src_a  = bus.a;
      assign src_b  = bus.b;
      assign src_d  = '0;
      assign src_ci = ~bus.bi;
      assign src_v  = bus.in_valid;
    end else begin : g_body
      assign src_a  = g_stage[k-1].q.a_hi;
      assign src_b  = g_stage[k-1].q.b_hi;
      assign src_d  = g_stage[k-1].q.d_lo;
      assign src_ci = g_stage[k-1].q.carry;
      assign src_v  = g_stage[k-1].q.valid;
    end

    addf_sub_slice #(.SEG(SEG)) u_slice (
      .a  (src_a[k*SEG +: SEG]),
      .b  (src_b[k*SEG +: SEG]),
      .ci (src_ci),
      .s  (sum),
      .co (co)
    );

    always_comb begin
      nxt                     = STAGE_RST;
      nxt.valid               = src_v;
      nxt.carry               = co;
      nxt.a_hi                = src_a;
      nxt.b_hi                = src_b;
      nxt.d_lo                = src_d;
      nxt.d_lo[k*SEG +: SEG]  = sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= STAGE_RST;
      end else if (adv[k]) begin
        q <= nxt;
      end
    end

    assign vld[k] = q.valid;
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.d         = g_stage[STAGES-1].q.d_lo;
  assign bus.bo        = ~g_stage[STAGES-1].q.carry;

`ifdef SUB_OVF_EN
  logic ovf_q;

  // Sign bits reach the last stage through the skew registers; top sum bit is d[W-1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv[STAGES-1]) begin
      ovf_q <= (g_stage[STAGES-1].src_a[WIDTH-1] != g_stage[STAGES-1].src_b[WIDTH-1]) &&
               (g_stage[STAGES-1].sum[SEG-1] != g_stage[STAGES-1].src_a[WIDTH-1]);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addf_sub_pipe.sv
// Self-checking bench for addf_sub_pipe: directed literals plus randomized traffic vs a queue model.
module tb_addf_sub_pipe;
  localparam int unsigned W = 15;
`ifdef SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addf_sub_pipe_if #(.WIDTH(W)) bus ();

  addf_sub_pipe #(.WIDTH(W), .STAGES(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_acc   = 0;
  int   full_at = -1;
  bit   drv_done;

  // Unsigned (W+1)-bit subtraction done in plain integer arithmetic.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    res_t r;
    int   diff;
    diff = int'(a) - int'(b) - int'(bi);
    r.bo = (diff < 0);
    r.d  = diff[W-1:0];
    r.ovf = OVF_ON && (a[W-1] != b[W-1]) && (r.d[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle a result is presented, match it against the oldest expected beat.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stale_beat: got out_valid=1 d=0x%0h expected no beat at %0t",
                   bus.d, $time);
        end else begin
          check("out_d", 32'(bus.d), 32'(exp_q[0].d));
          check("out_bo", 32'(bus.bo), 32'(exp_q[0].bo));
          check("out_ovf", 32'(bus.ovf), 32'(exp_q[0].ovf));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.bi));
        n_acc++;
      end
      if (bus.in_valid && !bus.in_ready && full_at < 0) full_at = n_acc;
    end
  end

  task automatic send_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input logic [W-1:0] ed, input logic ebo,
                          input logic eovf);
    int lat;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bi       = bi;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_d"}, 32'(bus.d), 32'(ed));
    check({name, "_bo"}, 32'(bus.bo), 32'(ebo));
    check({name, "_ovf"}, 32'(bus.ovf), 32'(eovf));
  endtask

  task automatic drive(input int n, input bit gaps);
    bit acc;
    int tries;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.bi       = 1'($urandom);
      tries        = 0;
      do begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        tries++;
      end while (!acc && tries < 200);
      if (!acc) check("in_accept_timeout", 0, 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bi        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_d", 32'(bus.d), 0);
    check("rst_bo", 32'(bus.bo), 0);
    check("rst_ovf", 32'(bus.ovf), 0);

    send_lit("basic", 15'h0005, 15'h0003, 1'b0, 15'h0002, 1'b0, 1'b0);
    send_lit("wrap0", 15'h0000, 15'h0001, 1'b0, 15'h7FFF, 1'b1, 1'b0);
    send_lit("wrap1", 15'h7FFF, 15'h7FFF, 1'b1, 15'h7FFF, 1'b1, 1'b0);
    send_lit("xseg", 15'h0020, 15'h0001, 1'b0, 15'h001F, 1'b0, 1'b0);
    send_lit("ovf1", 15'h3FFF, 15'h4000, 1'b0, 15'h7FFF, 1'b1, OVF_ON);
    send_lit("ovf0", 15'h0001, 15'h0001, 1'b0, 15'h0000, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Backpressure: sink stalls for cycles 2..7 of a 10-beat burst.
    n_acc   = 0;
    full_at = -1;
    fork
      drive(10, 1'b0);
      begin
        for (int c = 0; c < 40; c++) begin
          bus.out_ready = !(c >= 2 && c <= 7);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    check("bp_beats_before_full", full_at, 3);
    check("bp_accepted", n_acc, 10);
    drain("bp_drained");

    // Random traffic with random sink stalls and source gaps.
    drv_done = 1'b0;
    fork
      begin
        drive(200, 1'b1);
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("rand_drained");

    // Reset with three beats in flight.
    bus.out_ready = 1'b0;
    drive(3, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("postrst_in_ready", 32'(bus.in_ready), 1);
    check("postrst_out_valid", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("postrst_idle", 32'(bus.out_valid), 0);
    end

    send_lit("after_rst", 15'h1234, 15'h0234, 1'b1, 15'h0FFF, 1'b0, 1'b0);
    drain("final_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/addf_sub_pipe.md
Name: addf_sub_pipe

Overview:
- Pipelined WIDTH-bit subtractor (D = A - B - BI) with borrow-out.
- Built from CC_ADDF full-adder cells, with B inverted and carry-in taken as ~BI.
- Carry chain is split into STAGES registered segments; valid/ready handshake on both sides.
- Complements the plain ripple ADDF adder test: exercises the subtract direction plus pipelined carry hand-off between chain segments.

Parameters:
- WIDTH, 15, operand/result width in bits.
- STAGES, 3, number of pipeline segments. WIDTH % STAGES must be 0; default gives 5 bits per segment.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept operand beat.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bi  in  1  borrow-in.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- d  out  WIDTH  difference, a - b - bi mod 2^WIDTH.
- bo  out  1  borrow-out: 1 when a < b + bi (unsigned).
- ovf  out  1  signed overflow (only with SUB_OVF_EN; tied 0 otherwise).

Behaviour:
- Arithmetic:
  - Each bit i is a CC_ADDF with A=a[i], B=~b[i].
  - CI of bit 0 = ~bi; CO of top bit = ~bo.
  - Result is identical to unsigned (WIDTH+1)-bit a - b - bi: bo is the top bit, d is the low WIDTH bits.
- Pipeline:
  - Stage k (0..STAGES-1) computes slice k, i.e. bits [k*SEG +: SEG] with SEG = WIDTH/STAGES.
  - Stage k uses the registered carry from stage k-1; stage 0 uses ~bi.
  - Upper operand slices travel skewed through stage registers alongside the carry.
  - Lower result slices are carried forward so d is fully aligned at the output register.
- Latency: exactly STAGES cycles from input handshake to out_valid with no backpressure.
- Throughput: one beat per cycle.
- Handshake:
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - Stage k advances when its valid bit is 0 or stage k+1 advances; the last stage advances on out_ready.
  - in_ready = stage 0 advances. in_ready is combinational from out_ready through the stage valids; no combinational path from in_valid to in_ready.
  - out_valid, d and bo, ovf stay stable while out_valid & !out_ready.
- Full/empty:
  - Full: all stage valids are 1 and out_ready is 0, so in_ready is 0.
  - Full, then out_ready rises: one beat leaves and one beat may enter in the same cycle.
  - Empty: out_valid is 0, d/bo hold their last values (don't-care).
- Reset:
  - Asynchronous assert: all stage valid bits are 0, so out_valid=0 and in_ready=1 after release.
  - Data registers d, bo, ovf and skew registers clear to 0.
  - Reset mid-operation discards all in-flight beats; no partial beat is emitted after release.
- Wrap: d wraps modulo 2^WIDTH; there is no saturation.

Optional Feature:
- Macro: SUB_OVF_EN.
- Defined:
  - ovf = (a[W-1] != b[W-1]) & (d[W-1] != a[W-1]), with a and b treated as two's complement.
  - The sign bits of a and b are skewed to the last stage; ovf is registered with d and stalls with it.
- Undefined: ovf is tied to 0 and no extra registers are instantiated.

Decomposition:
- Package addf_sub_pkg:
  - Default WIDTH and STAGES constants.
  - Derived SEG.
  - Elaboration check function WIDTH % STAGES == 0.
  - Typedef for a stage payload struct {valid, carry, a_hi, b_hi, d_lo}.
- Sub-module addf_sub_slice: combinational SEG-bit CC_ADDF chain (a, ~b, ci -> s, co), instantiated once per stage.
- Top holds the stage registers and the handshake.

Test Plan:
- Basic subtract: a=0x0005, b=0x0003, bi=0 -> d=0x0002, bo=0, out_valid exactly 3 cycles after accept.
- Borrow wrap:
  - a=0x0000, b=0x0001, bi=0 -> d=0x7FFF, bo=1.
  - a=0x7FFF, b=0x7FFF, bi=1 -> d=0x7FFF, bo=1.
- Cross-segment borrow: a=0x0020, b=0x0001 -> d=0x001F, bo=0 (borrow ripples across the stage 0/1 boundary).
- Overflow (SUB_OVF_EN):
  - a=0x3FFF, b=0x4000 -> d=0x7FFF, ovf=1.
  - a=0x0001, b=0x0001 -> ovf=0.
- Backpressure:
  - Stream 10 back-to-back random beats with out_ready held 0 for cycles 2-7 -> in_ready drops after 3 beats held.
  - All 10 results arrive in order and match the model; outputs stay stable while stalled.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately; after release in_ready=1 and no stale beat ever appears.
